// File: rtl/router_src_sched_if.sv
// Source-side and router-side signals of the packet scheduler.
// master is the scheduler's view; slave is the sources'/router's view.
interface router_src_sched_if #(
  parameter int NSRC = 4
);
  logic [NSRC-1:0]   src_valid;
  logic [8*NSRC-1:0] src_data;
  logic [NSRC-1:0]   src_ready;
  logic [NSRC-1:0]   grant;
  logic [7:0]        rtr_data;
  logic              rtr_pkt_valid;
  logic              rtr_busy;
  logic              pkt_done;
  logic              pkt_drop;

  modport master (
    input  src_valid, src_data, rtr_busy,
    output src_ready, grant, rtr_data, rtr_pkt_valid, pkt_done, pkt_drop
  );

  modport slave (
    output src_valid, src_data, rtr_busy,
    input  src_ready, grant, rtr_data, rtr_pkt_valid, pkt_done, pkt_drop
  );
endinterface

// File: rtl/router_src_sched.sv
// Round-robin store-and-forward scheduler: collects one whole packet from the
// granted source, then streams header+payload gap-free and appends parity.
module router_src_sched #(
  parameter int NSRC = 4,
  parameter int GAP  = 2
) (
  input logic                clock,
  input logic                resetn,
  router_src_sched_if.master bus
);
  localparam int PTR_W = $clog2(NSRC);
  localparam int GAP_W = 4;

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_SEND, S_PARITY, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] gidx_q, gidx_d;
  logic [NSRC-1:0]  grant_q, grant_d;
  logic [5:0]       wr_ptr_q, wr_ptr_d;
  logic [5:0]       rd_ptr_q, rd_ptr_d;
  logic [5:0]       len_q, len_d;
  logic [1:0]       addr_q, addr_d;
  logic [7:0]       parity_q, parity_d;
  logic [7:0]       rtr_data_q, rtr_data_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic             pkt_done_q, pkt_done_d;
  logic             pkt_drop_q, pkt_drop_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  logic [7:0]       buf_mem [64];
  logic             buf_we;

  logic             any_req;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand;
  logic [7:0]       cur_byte;
  logic             cur_valid;
  logic [5:0]       eff_len;
  logic [1:0]       eff_addr;
  logic [7:0]       hdr_byte;

  // Scan from the lowest offset last so the closest requester to rr_ptr wins.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      cand = PTR_W'((int'(rr_ptr_q) + i) % NSRC);
      if (bus.src_valid[cand]) begin
        any_req = 1'b1;
        win_idx = cand;
      end
    end
  end

  // The first byte is the header: len/addr come straight off the bus that cycle.
  assign cur_byte  = bus.src_data[{gidx_q, 3'b000} +: 8];
  assign cur_valid = bus.src_valid[gidx_q];
  assign eff_len   = (wr_ptr_q == 6'd0) ? cur_byte[7:2] : len_q;
  assign eff_addr  = (wr_ptr_q == 6'd0) ? cur_byte[1:0] : addr_q;
  assign hdr_byte  = (wr_ptr_q == 6'd0) ? cur_byte : buf_mem[6'd0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    addr_d      = addr_q;
    parity_d    = parity_q;
    rtr_data_d  = rtr_data_q;
    pkt_valid_d = pkt_valid_q;
    pkt_done_d  = 1'b0;
    pkt_drop_d  = 1'b0;
    gap_cnt_d   = gap_cnt_q;
    buf_we      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d  = NSRC'(1) << win_idx;
          gidx_d   = win_idx;
          rr_ptr_d = PTR_W'((int'(win_idx) + 1) % NSRC);
          wr_ptr_d = '0;
          parity_d = '0;
          state_d  = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (cur_valid) begin
          buf_we   = 1'b1;
          parity_d = parity_q ^ cur_byte;
          wr_ptr_d = wr_ptr_q + 6'd1;
          if (wr_ptr_q == 6'd0) begin
            len_d  = cur_byte[7:2];
            addr_d = cur_byte[1:0];
          end
          if (wr_ptr_q == eff_len) begin
            if (eff_addr == 2'b11) begin
              grant_d    = '0;
              pkt_drop_d = 1'b1;
              gap_cnt_d  = '0;
              state_d    = S_GAP;
            end else begin
              rtr_data_d  = hdr_byte;
              pkt_valid_d = 1'b1;
              rd_ptr_d    = 6'd1;
              state_d     = S_SEND;
            end
          end
        end
      end

      // rd_ptr points one past the byte on rtr_data; wraps cleanly at len 63.
      S_SEND: begin
        if (!bus.rtr_busy) begin
          if (6'(rd_ptr_q - 6'd1) == len_q) begin
            rtr_data_d  = parity_q;
            pkt_valid_d = 1'b0;
            state_d     = S_PARITY;
          end else begin
            rtr_data_d = buf_mem[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + 6'd1;
          end
        end
      end

      S_PARITY: begin
        if (!bus.rtr_busy) begin
          pkt_done_d = 1'b1;
          rtr_data_d = '0;
          grant_d    = '0;
          gap_cnt_d  = '0;
          state_d    = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q    <= '0;
      gidx_q      <= '0;
      grant_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      parity_q    <= '0;
      rtr_data_q  <= '0;
      pkt_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_drop_q  <= 1'b0;
      gap_cnt_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      gidx_q      <= gidx_d;
      grant_q     <= grant_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      parity_q    <= parity_d;
      rtr_data_q  <= rtr_data_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_done_q  <= pkt_done_d;
      pkt_drop_q  <= pkt_drop_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  // NOTE: the buffer is deliberately not reset; a byte is only read after it was written.
  always_ff @(posedge clock) begin
    if (buf_we) buf_mem[wr_ptr_q] <= cur_byte;
  end

  assign bus.src_ready     = (state_q == S_COLLECT) ? grant_q : '0;
  assign bus.grant         = grant_q;
  assign bus.rtr_data      = rtr_data_q;
  assign bus.rtr_pkt_valid = pkt_valid_q;
  assign bus.pkt_done      = pkt_done_q;
  assign bus.pkt_drop      = pkt_drop_q;
endmodule
